// File: rtl/rv32im_exec_unit_if.sv
// Decode/execute/memory signal bundle for the RV32IM execute stage.
// The master side (decode + data memory) drives operands; the slave side is the execute unit.
interface rv32im_exec_unit_if;
    logic [4:0]  alu_opcode_i;
    logic [3:0]  lsu_opcode_i;
    logic [3:0]  br_opcode_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [31:0] imm_i;
    logic [1:0]  data_origin_i;
    logic [2:0]  data_target_i;
    logic [31:0] val_memdatard_i;
    logic [31:0] val_memdatawr_o;
    logic [31:0] val_memaddr_o;
    logic        is_branch_i;
    logic        is_condition_i;
    logic [31:0] curr_pc_i;
    logic [31:0] new_pc_o;
    logic [31:0] csr_output_i;
    logic [31:0] data_o;

    modport slave (
        input  alu_opcode_i, lsu_opcode_i, br_opcode_i, rs1_i, rs2_i, imm_i,
               data_origin_i, data_target_i, val_memdatard_i, is_branch_i,
               is_condition_i, curr_pc_i, csr_output_i,
        output val_memdatawr_o, val_memaddr_o, new_pc_o, data_o
    );

    modport master (
        output alu_opcode_i, lsu_opcode_i, br_opcode_i, rs1_i, rs2_i, imm_i,
               data_origin_i, data_target_i, val_memdatard_i, is_branch_i,
               is_condition_i, curr_pc_i, csr_output_i,
        input  val_memdatawr_o, val_memaddr_o, new_pc_o, data_o
    );
endinterface

// File: rtl/rv32im_exec_unit.sv
// RV32IM execute stage: ALU with M-extension, load/store formatting and branch
// resolution. Writeback value and next PC are registered; memory address/data are not.
module rv32im_exec_unit #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic               clk_i,
    input logic               rst_i,
    rv32im_exec_unit_if.slave bus
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,  ALU_SUB = 5'd1,   ALU_SLL = 5'd2,     ALU_SLT = 5'd3,
        ALU_SLTU = 5'd4, ALU_XOR = 5'd5,   ALU_SRL = 5'd6,     ALU_SRA = 5'd7,
        ALU_OR = 5'd8,   ALU_AND = 5'd9,   ALU_MUL = 5'd10,    ALU_MULH = 5'd11,
        ALU_MULHSU = 5'd12, ALU_MULHU = 5'd13, ALU_DIV = 5'd14, ALU_DIVU = 5'd15,
        ALU_REM = 5'd16, ALU_REMU = 5'd17
    } alu_op_e;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0, LSU_LB = 4'd1, LSU_LH = 4'd2, LSU_LW = 4'd3, LSU_LBU = 4'd4,
        LSU_LHU = 4'd5,  LSU_SB = 4'd6, LSU_SH = 4'd7, LSU_SW = 4'd8
    } lsu_op_e;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0, BR_BEQ = 4'd1,  BR_BNE = 4'd2, BR_BLT = 4'd3, BR_BGE = 4'd4,
        BR_BLTU = 4'd5, BR_BGEU = 4'd6, BR_JAL = 4'd7, BR_JALR = 4'd8
    } br_op_e;

    typedef enum logic [2:0] {
        WB_ALU = 3'd0, WB_LOAD = 3'd1, WB_LINK = 3'd2, WB_CSR = 3'd3, WB_IMM = 3'd4
    } wb_sel_e;

    logic [W-1:0]   op_a, op_b;
    logic [4:0]     shamt;
    logic [2*W-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [2*W-1:0] prod_ss, prod_su, prod_uu;
    logic           div_by_zero, div_ovf;
    logic [W-1:0]   div_b_safe;
    logic [W-1:0]   quot_s, rem_s, quot_u, rem_u;
    logic [W-1:0]   alu_res;

    logic [W-1:0]   mem_addr;
    logic [W-1:0]   load_shifted;
    logic [15:0]    load_half;
    logic [W-1:0]   load_data;
    logic [W-1:0]   store_data;

    logic           br_cond, br_taken;
    logic [W-1:0]   pc_plus4, br_target;

    logic [W-1:0]   data_d, data_q;
    logic [W-1:0]   new_pc_d, new_pc_q;

    assign op_a  = bus.data_origin_i[0] ? bus.curr_pc_i : bus.rs1_i;
    assign op_b  = bus.data_origin_i[1] ? bus.imm_i     : bus.rs2_i;
    assign shamt = op_b[4:0];

    // Low 2W bits of the product of sign/zero-extended operands give every signedness mix.
    assign a_sx    = {{W{op_a[W-1]}}, op_a};
    assign b_sx    = {{W{op_b[W-1]}}, op_b};
    assign a_zx    = {{W{1'b0}}, op_a};
    assign b_zx    = {{W{1'b0}}, op_b};
    assign prod_ss = a_sx * b_sx;
    assign prod_su = a_sx * b_zx;
    assign prod_uu = a_zx * b_zx;

    assign div_by_zero = (op_b == '0);
    assign div_ovf     = (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
    // The divider never sees the zero or overflow cases; those results are patched below.
    assign div_b_safe  = (div_by_zero || div_ovf) ? W'(1) : op_b;
    assign quot_s      = W'($signed(op_a) / $signed(div_b_safe));
    assign rem_s       = W'($signed(op_a) % $signed(div_b_safe));
    assign quot_u      = op_a / div_b_safe;
    assign rem_u       = op_a % div_b_safe;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        alu_res = op_a + op_b;
        case (bus.alu_opcode_i)
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_SLL:    alu_res = op_a << shamt;
            ALU_SLT:    alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:   alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SRL:    alu_res = op_a >> shamt;
            ALU_SRA:    alu_res = W'($signed(op_a) >>> shamt);
            ALU_OR:     alu_res = op_a | op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_MUL:    alu_res = prod_uu[W-1:0];
            ALU_MULH:   alu_res = prod_ss[2*W-1:W];
            ALU_MULHSU: alu_res = prod_su[2*W-1:W];
            ALU_MULHU:  alu_res = prod_uu[2*W-1:W];
            ALU_DIV:    alu_res = div_by_zero ? '1 : (div_ovf ? op_a : quot_s);
            ALU_DIVU:   alu_res = div_by_zero ? '1 : quot_u;
            ALU_REM:    alu_res = div_by_zero ? op_a : (div_ovf ? '0 : rem_s);
            ALU_REMU:   alu_res = div_by_zero ? op_a : rem_u;
            default:    alu_res = op_a + op_b;
        endcase
    end

    assign mem_addr     = bus.rs1_i + bus.imm_i;
    assign load_shifted = bus.val_memdatard_i >> {mem_addr[1:0], 3'b000};
    assign load_half    = mem_addr[1] ? bus.val_memdatard_i[31:16] : bus.val_memdatard_i[15:0];

    always_comb begin
        load_data  = '0;
        store_data = '0;
        case (bus.lsu_opcode_i)
            LSU_LB:  load_data = {{(W-8){load_shifted[7]}}, load_shifted[7:0]};
            LSU_LH:  load_data = {{(W-16){load_half[15]}}, load_half};
            LSU_LW:  load_data = bus.val_memdatard_i;
            LSU_LBU: load_data = {{(W-8){1'b0}}, load_shifted[7:0]};
            LSU_LHU: load_data = {{(W-16){1'b0}}, load_half};
            LSU_SB:  store_data = {4{bus.rs2_i[7:0]}};
            LSU_SH:  store_data = {2{bus.rs2_i[15:0]}};
            LSU_SW:  store_data = bus.rs2_i;
            default: begin
                load_data  = '0;
                store_data = '0;
            end
        endcase
    end

    assign bus.val_memaddr_o   = mem_addr;
    assign bus.val_memdatawr_o = store_data;

    always_comb begin
        br_cond = 1'b0;
        case (bus.br_opcode_i)
            BR_BEQ:  br_cond = (bus.rs1_i == bus.rs2_i);
            BR_BNE:  br_cond = (bus.rs1_i != bus.rs2_i);
            BR_BLT:  br_cond = ($signed(bus.rs1_i) <  $signed(bus.rs2_i));
            BR_BGE:  br_cond = ($signed(bus.rs1_i) >= $signed(bus.rs2_i));
            BR_BLTU: br_cond = (bus.rs1_i <  bus.rs2_i);
            BR_BGEU: br_cond = (bus.rs1_i >= bus.rs2_i);
            BR_JAL,
            BR_JALR: br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign pc_plus4  = bus.curr_pc_i + W'(4);
    assign br_target = (bus.br_opcode_i == BR_JALR) ? (mem_addr & ~W'(1))
                                                    : (bus.curr_pc_i + bus.imm_i);
    assign br_taken  = bus.is_branch_i & (~bus.is_condition_i | br_cond);

    always_comb begin
        new_pc_d = br_taken ? br_target : pc_plus4;
        case (bus.data_target_i)
            WB_LOAD: data_d = load_data;
            WB_LINK: data_d = pc_plus4;
            WB_CSR:  data_d = bus.csr_output_i;
            WB_IMM:  data_d = bus.imm_i;
            default: data_d = alu_res;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q   <= '0;
            new_pc_q <= RESET_PC;
        end else begin
            data_q   <= data_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign bus.data_o   = data_q;
    assign bus.new_pc_o = new_pc_q;
endmodule

// File: tb/tb_rv32im_exec_unit.sv
// Directed-vector bench for rv32im_exec_unit with hand-computed expectations.
module tb_rv32im_exec_unit;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3, SLTU = 5'd4,
                           XOR = 5'd5, SRL = 5'd6, SRA = 5'd7, OR = 5'd8, AND = 5'd9,
                           MUL = 5'd10, MULH = 5'd11, MULHSU = 5'd12, MULHU = 5'd13,
                           DIV = 5'd14, DIVU = 5'd15, REM = 5'd16, REMU = 5'd17;
    localparam logic [3:0] LNONE = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                           LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;
    localparam logic [3:0] BNONE = 4'd0, BEQ = 4'd1, BNE = 4'd2, BLT = 4'd3, BGE = 4'd4,
                           BLTU = 4'd5, BGEU = 4'd6, JAL = 4'd7, JALR = 4'd8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    rv32im_exec_unit_if bus();

    rv32im_exec_unit #(.DATA_WIDTH(32), .RESET_PC(TB_RESET_PC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alu_opcode_i    = ADD;
        bus.lsu_opcode_i    = LNONE;
        bus.br_opcode_i     = BNONE;
        bus.rs1_i           = '0;
        bus.rs2_i           = '0;
        bus.imm_i           = '0;
        bus.data_origin_i   = 2'd0;
        bus.data_target_i   = 3'd0;
        bus.val_memdatard_i = '0;
        bus.is_branch_i     = 1'b0;
        bus.is_condition_i  = 1'b0;
        bus.curr_pc_i       = '0;
        bus.csr_output_i    = '0;
    endtask

    task automatic run_alu(input string tag, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        bus.alu_opcode_i  = op;
        bus.rs1_i         = a;
        bus.rs2_i         = b;
        bus.data_origin_i = 2'd0;
        bus.data_target_i = 3'd0;
        step();
        check(tag, bus.data_o, exp);
    endtask

    task automatic run_br(input string tag, input logic [3:0] op, input logic cond,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] exp_pc);
        bus.br_opcode_i    = op;
        bus.is_branch_i    = 1'b1;
        bus.is_condition_i = cond;
        bus.rs1_i          = a;
        bus.rs2_i          = b;
        bus.curr_pc_i      = pc;
        bus.imm_i          = imm;
        step();
        check(tag, bus.new_pc_o, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        check("rst1_data", bus.data_o, 32'h0);
        check("rst1_pc", bus.new_pc_o, TB_RESET_PC);
        step();
        check("rst2_data", bus.data_o, 32'h0);
        check("rst2_pc", bus.new_pc_o, TB_RESET_PC);
        rst = 1'b0;

        // Basic ALU stream with sequential PCs
        bus.curr_pc_i = 32'h0;
        run_alu("add", ADD, 32'd6, 32'd100, 32'd106);
        check("add_pc", bus.new_pc_o, 32'h4);
        bus.curr_pc_i = 32'h4;
        run_alu("or", OR, 32'd6, 32'd100, 32'd102);
        check("or_pc", bus.new_pc_o, 32'h8);
        bus.curr_pc_i = 32'h8;
        run_alu("slt", SLT, 32'd6, 32'd100, 32'd1);
        check("slt_pc", bus.new_pc_o, 32'hC);

        run_alu("sub", SUB, 32'd6, 32'd100, 32'hFFFF_FFA2);
        run_alu("sll_wrap", SLL, 32'h1, 32'd33, 32'h2);
        run_alu("srl", SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        run_alu("sra", SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_alu("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0);
        run_alu("slt_neg", SLT, 32'hFFFF_FFFF, 32'd1, 32'h1);
        run_alu("xor", XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        run_alu("and", AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
        run_alu("mul", MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        run_alu("mulhu", MULHU, 32'hFFFF_FFFF, 32'd2, 32'h1);
        run_alu("mulh", MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_alu("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_alu("div_zero", DIV, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_alu("divu_zero", DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_alu("rem_zero", REM, 32'd7, 32'd0, 32'd7);
        run_alu("remu_zero", REMU, 32'd7, 32'd0, 32'd7);
        run_alu("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_alu("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_alu("div_trunc", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_alu("rem_sign", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_alu("divu", DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        run_alu("remu", REMU, 32'd100, 32'd7, 32'd2);
        run_alu("bad_op_add", 5'd25, 32'd10, 32'd5, 32'd15);

        // Operand origin: A = pc, B = imm
        bus.curr_pc_i     = 32'h100;
        bus.imm_i         = 32'h10;
        bus.rs1_i         = 32'h5555;
        bus.rs2_i         = 32'h7777;
        bus.alu_opcode_i  = ADD;
        bus.data_origin_i = 2'd3;
        step();
        check("origin_pc_imm", bus.data_o, 32'h110);
        bus.data_origin_i = 2'd0;

        // Writeback selects
        bus.csr_output_i  = 32'hC5C5_0001;
        bus.data_target_i = 3'd3;
        step();
        check("wb_csr", bus.data_o, 32'hC5C5_0001);
        bus.data_target_i = 3'd4;
        step();
        check("wb_imm", bus.data_o, 32'h10);
        bus.data_target_i = 3'd6;
        step();
        check("wb_alias_alu", bus.data_o, 32'h5555 + 32'h7777);

        // Loads
        bus.data_target_i   = 3'd1;
        bus.rs1_i           = 32'h100;
        bus.imm_i           = 32'd3;
        bus.val_memdatard_i = 32'hAB00_0000;
        bus.lsu_opcode_i    = LBU;
        #1;
        check("ld_addr", bus.val_memaddr_o, 32'h103);
        check("ld_wdata_zero", bus.val_memdatawr_o, 32'h0);
        step();
        check("lbu", bus.data_o, 32'h0000_00AB);
        bus.lsu_opcode_i = LB;
        step();
        check("lb", bus.data_o, 32'hFFFF_FFAB);
        bus.val_memdatard_i = 32'h8001_1234;
        bus.lsu_opcode_i    = LH;
        step();
        check("lh_hi", bus.data_o, 32'hFFFF_8001);
        bus.imm_i        = 32'd0;
        bus.lsu_opcode_i = LHU;
        step();
        check("lhu_lo", bus.data_o, 32'h0000_1234);
        bus.lsu_opcode_i = LB;
        bus.imm_i        = 32'd1;
        step();
        check("lb_b1", bus.data_o, 32'h0000_0012);
        bus.lsu_opcode_i = LW;
        step();
        check("lw", bus.data_o, 32'h8001_1234);
        bus.lsu_opcode_i = LNONE;
        step();
        check("ld_none", bus.data_o, 32'h0);

        // Stores
        bus.rs2_i        = 32'h0000_1234;
        bus.lsu_opcode_i = SH;
        #1;
        check("sh_wdata", bus.val_memdatawr_o, 32'h1234_1234);
        step();
        check("st_ld_zero", bus.data_o, 32'h0);
        bus.rs2_i        = 32'hDEAD_BEA5;
        bus.lsu_opcode_i = SB;
        #1;
        check("sb_wdata", bus.val_memdatawr_o, 32'hA5A5_A5A5);
        bus.lsu_opcode_i = SW;
        #1;
        check("sw_wdata", bus.val_memdatawr_o, 32'hDEAD_BEA5);
        bus.lsu_opcode_i  = LNONE;
        bus.data_target_i = 3'd0;

        // Branches
        run_br("beq_taken", BEQ, 1'b1, 32'd5, 32'd5, 32'h40, 32'hFFFF_FFF8, 32'h38);
        run_br("bne_not", BNE, 1'b1, 32'd5, 32'd5, 32'h40, 32'hFFFF_FFF8, 32'h44);
        run_br("blt_taken", BLT, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h20, 32'h60);
        run_br("bltu_not", BLTU, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h20, 32'h44);
        run_br("bgeu_taken", BGEU, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h20, 32'h60);
        run_br("bge_not", BGE, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h20, 32'h44);
        run_br("jal", JAL, 1'b0, 32'd0, 32'd0, 32'h80, 32'h100, 32'h180);
        run_br("none_cond", BNONE, 1'b1, 32'd5, 32'd5, 32'h40, 32'h20, 32'h44);
        bus.br_opcode_i = BEQ;
        bus.is_branch_i = 1'b0;
        step();
        check("not_branch", bus.new_pc_o, 32'h44);

        // JALR with link writeback
        bus.data_target_i = 3'd2;
        run_br("jalr_pc", JALR, 1'b0, 32'h1001, 32'd0, 32'h20, 32'd2, 32'h1002);
        check("jalr_link", bus.data_o, 32'h24);

        // Mid-stream reset
        rst = 1'b1;
        #1;
        check("rst_addr_comb", bus.val_memaddr_o, 32'h1003);
        step();
        check("mid_rst_data", bus.data_o, 32'h0);
        check("mid_rst_pc", bus.new_pc_o, TB_RESET_PC);
        rst = 1'b0;
        step();
        check("post_rst_pc", bus.new_pc_o, 32'h1002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
